// File: rtl/rx_pkg.sv
// Shared types and constants for the serial receive control path.
package rx_pkg;

    localparam int unsigned FRAME_BITS = 9;
    localparam int unsigned DATA_BITS  = 8;
    localparam logic        IDLE_LINE  = 1'b1;

    typedef enum logic [2:0] {
        IDLE,
        START,
        VALIDATE,
        RECEIVE,
        CHECK,
        LOAD
    } rx_state_t;

endpackage

// File: rtl/start_bit_det.sv
// Multi-flop synchronizer for the raw serial line plus 1->0 edge detect on the synced value.
module start_bit_det
    import rx_pkg::*;
#(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic n_rst,
    input  logic serial_in,
    output logic sync_bit,
    output logic start_edge
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   prev_q;

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            sync_q <= {SYNC_STAGES{IDLE_LINE}};
            prev_q <= IDLE_LINE;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], serial_in};
            prev_q <= sync_q[SYNC_STAGES-1];
        end
    end

    assign sync_bit   = sync_q[SYNC_STAGES-1];
    assign start_edge = prev_q & ~sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/rx_control.sv
// Receive control: start detect, frame assembly, framing check and buffered byte handshake.
// Optional start-bit validation window is enabled by defining RX_START_VALIDATE_EN.
module rx_control
    import rx_pkg::*;
#(
    parameter int unsigned SYNC_STAGES        = 2,
    parameter int unsigned START_CHECK_CYCLES = 4
) (
    input  logic                 clk,
    input  logic                 n_rst,
    input  logic                 serial_in,
    input  logic                 shift_strobe,
    input  logic                 packet_done,
    input  logic                 data_read,
    output logic                 enable_timer,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 data_ready,
    output logic                 overrun_error,
    output logic                 framing_error
);

    if (SYNC_STAGES < 2) begin : g_bad_sync
        $error("SYNC_STAGES must be at least 2");
    end
    if (START_CHECK_CYCLES < 1) begin : g_bad_check
        $error("START_CHECK_CYCLES must be at least 1");
    end

    logic sync_bit, start_edge;

    start_bit_det #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_start_bit_det (
        .clk       (clk),
        .n_rst     (n_rst),
        .serial_in (serial_in),
        .sync_bit  (sync_bit),
        .start_edge(start_edge)
    );

    rx_state_t             state_q, state_d;
    logic [FRAME_BITS-1:0] sr_q, sr_d;
    logic [DATA_BITS-1:0]  data_q, data_d;
    logic                  ready_q, ready_d;
    logic                  over_q, over_d;
    logic                  frame_q, frame_d;
    logic                  en_q, en_d;

`ifdef RX_START_VALIDATE_EN
    localparam int unsigned CntW = $clog2(START_CHECK_CYCLES + 1);
    logic [CntW-1:0] cnt_q, cnt_d;

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) cnt_q <= '0;
        else        cnt_q <= cnt_d;
    end
`endif

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:     if (start_edge) state_d = START;
`ifdef RX_START_VALIDATE_EN
            START:    state_d = VALIDATE;
            VALIDATE: begin
                if (sync_bit) begin
                    state_d = IDLE;
                end else if (cnt_q == CntW'(START_CHECK_CYCLES - 1)) begin
                    state_d = RECEIVE;
                end
            end
`else
            START:    state_d = RECEIVE;
            VALIDATE: state_d = IDLE;
`endif
            RECEIVE:  if (packet_done) state_d = CHECK;
            CHECK:    state_d = sr_q[FRAME_BITS-1] ? LOAD : IDLE;
            LOAD:     state_d = IDLE;
            default:  state_d = IDLE;
        endcase
    end

    always_comb begin
        sr_d    = sr_q;
        data_d  = data_q;
        ready_d = ready_q;
        over_d  = over_q;
        frame_d = frame_q;
`ifdef RX_START_VALIDATE_EN
        cnt_d   = cnt_q;
`endif
        // A read outside LOAD acknowledges the buffer; in LOAD the new byte takes priority.
        if (data_read && state_q != LOAD) begin
            ready_d = 1'b0;
            over_d  = 1'b0;
        end
        case (state_q)
            START: begin
                frame_d = 1'b0;
                sr_d    = '1;
`ifdef RX_START_VALIDATE_EN
                cnt_d   = '0;
`endif
            end
`ifdef RX_START_VALIDATE_EN
            VALIDATE: cnt_d = cnt_q + 1'b1;
`endif
            RECEIVE: begin
                if (shift_strobe) sr_d = {sync_bit, sr_q[FRAME_BITS-1:1]};
            end
            CHECK: begin
                if (!sr_q[FRAME_BITS-1]) frame_d = 1'b1;
            end
            LOAD: begin
                data_d  = sr_q[DATA_BITS-1:0];
                ready_d = 1'b1;
                over_d  = ready_q && !data_read;
            end
            default: ;
        endcase
        en_d = (state_d == RECEIVE);
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            sr_q    <= '1;
            data_q  <= '0;
            ready_q <= 1'b0;
            over_q  <= 1'b0;
            frame_q <= 1'b0;
            en_q    <= 1'b0;
        end else begin
            sr_q    <= sr_d;
            data_q  <= data_d;
            ready_q <= ready_d;
            over_q  <= over_d;
            frame_q <= frame_d;
            en_q    <= en_d;
        end
    end

    assign enable_timer  = en_q;
    assign rx_data       = data_q;
    assign data_ready    = ready_q;
    assign overrun_error = over_q;
    assign framing_error = frame_q;

endmodule

// File: tb/tb_rx_control.sv
// Bench for rx_control: the bench plays the bit timer and checks against a byte-level model.
module tb_rx_control;

    logic       clk = 1'b0;
    logic       n_rst;
    logic       serial_in;
    logic       shift_strobe;
    logic       packet_done;
    logic       data_read;
    logic       enable_timer;
    logic [7:0] rx_data;
    logic       data_ready;
    logic       overrun_error;
    logic       framing_error;

    int n_vec = 0;
    int n_err = 0;

    // Consumer-visible model state.
    logic [7:0] m_data;
    logic       m_ready, m_over, m_frame;

    always #5 clk = ~clk;

    rx_control #(
        .SYNC_STAGES       (2),
        .START_CHECK_CYCLES(4)
    ) dut (
        .clk          (clk),
        .n_rst        (n_rst),
        .serial_in    (serial_in),
        .shift_strobe (shift_strobe),
        .packet_done  (packet_done),
        .data_read    (data_read),
        .enable_timer (enable_timer),
        .rx_data      (rx_data),
        .data_ready   (data_ready),
        .overrun_error(overrun_error),
        .framing_error(framing_error)
    );

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk_all(input string tag);
        chk({tag, "_data"}, rx_data, m_data);
        chk({tag, "_ready"}, {7'b0, data_ready}, {7'b0, m_ready});
        chk({tag, "_overrun"}, {7'b0, overrun_error}, {7'b0, m_over});
        chk({tag, "_framing"}, {7'b0, framing_error}, {7'b0, m_frame});
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic model_reset();
        m_data  = 8'h00;
        m_ready = 1'b0;
        m_over  = 1'b0;
        m_frame = 1'b0;
    endtask

    // Sends start bit, 8 data bits LSB-first and a stop bit. abort_after>0 stops after that
    // many strobes with no packet_done.
    task automatic send_frame(input logic [7:0] d, input logic stop, input logic pd_coincide,
                              input logic rd_in_load, input int abort_after);
        logic [8:0] bits;
        int         waited;
        bits      = {stop, d};
        serial_in = 1'b1;
        repeat (4) tick();
        serial_in = 1'b0;
        waited    = 0;
        while (enable_timer !== 1'b1 && waited < 40) begin
            tick();
            waited++;
        end
        chk("enable_rise", {7'b0, enable_timer}, 8'h01);
        m_frame = 1'b0;
        for (int i = 0; i < 9; i++) begin
            serial_in = bits[i];
            repeat (4) tick();
            shift_strobe = 1'b1;
            if (i == 8 && pd_coincide) packet_done = 1'b1;
            tick();
            shift_strobe = 1'b0;
            packet_done  = 1'b0;
            if (abort_after == i + 1) return;
        end
        if (!pd_coincide) begin
            tick();
            packet_done = 1'b1;
            tick();
            packet_done = 1'b0;
        end
        chk("enable_low_check", {7'b0, enable_timer}, 8'h00);
        tick();
        chk("ready_latency", {7'b0, data_ready}, {7'b0, m_ready});
        if (rd_in_load) data_read = 1'b1;
        tick();
        data_read = 1'b0;
        serial_in = 1'b1;
        m_frame   = !stop;
        if (stop) begin
            if (m_ready && !rd_in_load) m_over = 1'b1;
            else if (rd_in_load)        m_over = 1'b0;
            m_data  = d;
            m_ready = 1'b1;
        end
    endtask

    task automatic read_pulse();
        data_read = 1'b1;
        tick();
        data_read = 1'b0;
        m_ready   = 1'b0;
        m_over    = 1'b0;
        chk_all("read");
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int seen;
        logic [7:0] d;
        logic       stop, pd;

        n_rst        = 1'b0;
        serial_in    = 1'b0;
        shift_strobe = 1'b0;
        packet_done  = 1'b0;
        data_read    = 1'b0;
        model_reset();
        repeat (3) tick();
        chk_all("reset");
        chk("reset_enable", {7'b0, enable_timer}, 8'h00);

        serial_in = 1'b1;
        tick();
        n_rst = 1'b1;
        seen  = 0;
        repeat (10) begin
            tick();
            if (enable_timer) seen = 1;
        end
        chk("no_spurious_start", 8'(seen), 8'h00);

        send_frame(8'hA5, 1'b1, 1'b1, 1'b0, 0);
        chk_all("good_a5");
        read_pulse();

        send_frame(8'h3C, 1'b0, 1'b1, 1'b0, 0);
        chk_all("bad_stop_3c");
        send_frame(8'h81, 1'b1, 1'b0, 1'b0, 0);
        chk_all("good_81");
        read_pulse();

        send_frame(8'h11, 1'b1, 1'b1, 1'b0, 0);
        chk_all("ovr_11");
        send_frame(8'h22, 1'b1, 1'b0, 1'b0, 0);
        chk_all("ovr_22");
        read_pulse();

        send_frame(8'h44, 1'b1, 1'b1, 1'b0, 0);
        chk_all("hold_44");
        send_frame(8'h55, 1'b1, 1'b1, 1'b1, 0);
        chk_all("read_in_load_55");

        send_frame(8'hC3, 1'b1, 1'b1, 1'b0, 4);
        #2;
        n_rst = 1'b0;
        #1;
        model_reset();
        chk_all("midframe_reset");
        chk("midframe_reset_enable", {7'b0, enable_timer}, 8'h00);
        serial_in = 1'b1;
        repeat (3) tick();
        n_rst = 1'b1;
        send_frame(8'hF0, 1'b1, 1'b1, 1'b0, 0);
        chk_all("after_reset_f0");
        read_pulse();

`ifdef RX_START_VALIDATE_EN
        serial_in = 1'b0;
        repeat (2) tick();
        serial_in = 1'b1;
        seen = 0;
        repeat (20) begin
            tick();
            if (enable_timer) seen = 1;
        end
        chk("glitch_no_enable", 8'(seen), 8'h00);
        chk_all("glitch");
`endif

        for (int k = 0; k < 16; k++) begin
            d    = 8'($urandom);
            stop = ($urandom_range(0, 3) != 0);
            pd   = 1'($urandom_range(0, 1));
            send_frame(d, stop, pd, 1'b0, 0);
            chk_all("random_frame");
            if ($urandom_range(0, 1) == 1) read_pulse();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
